pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Run-control sequencer for the 3-stage IF→ID→EX pipeline. It drives the shared `stall` line into the IF stage, IF/ID register and ID/EX register. It tracks which pipeline slots hold real instructions and stops the pipeline on an external halt request or on a HALT opcode reaching EX. It also supports single-step debug and counts retired instructions.

## Interface
- `HALT_OPCODE`, default 4'hF: opcode that stops the pipeline when it retires from EX.
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset; synchronous, active-low.
- `start`  in  1  enter or resume RUN; level sampled each edge.
- `step`  in  1  request one advance cycle; level sampled each edge.
- `halt_req`  in  1  external stop request.
- `opcode_ex`  in  4  opcode currently held in the ID/EX register.
- `stall`  out  1  pipeline freeze to IF, IF/ID and ID/EX.
- `ex_valid`  out  1  ID/EX holds a real (non-bubble) instruction.
- `busy`  out  1  state is RUN or STEP.
- `halted`  out  1  state is HALTED.
- `state`  out  2  current state: IDLE=0, RUN=1, STEP=2, HALTED=3.
- `retired_cnt`  out  CNT_W  saturating count of retired instructions.

## Operation
- `stall` is combinational from the state: `stall = !(state==RUN || state==STEP)`. `busy = !stall`.
- An advance cycle is any cycle with `stall=0`.
- Slot valid tracking uses registered `v_id` and `v_ex`; `ex_valid = v_ex`.
  - On an advance cycle: `v_id` <= 1, `v_ex` <= `v_id`.
  - Otherwise both hold.
- Retire: an advance cycle with `v_ex=1`. At that edge, `retired_cnt` increments and saturates at all-ones.
- Halt-op: a retire whose `opcode_ex==HALT_OPCODE`. The halting instruction is counted.
- Input priority within a cycle: `halt_req` > Halt-op > `start` > `step`.
- IDLE:
  - `start` → RUN.
  - `step` → STEP, with return bit `ret` <= 0.
  - `halt_req` → HALTED.
- RUN:
  - `halt_req` or Halt-op → HALTED.
  - `start` and `step` are ignored.
- STEP: lasts exactly one cycle, which is one advance.
  - Halt-op or `halt_req` → HALTED.
  - Otherwise → IDLE if `ret=0`, HALTED if `ret=1`.
- HALTED:
  - `start` → RUN.
  - `step` → STEP, with `ret` <= 1.
  - `halt_req` while in HALTED: remain in HALTED.
- `start` and `step` are level-sensitive. A `step` held high in IDLE produces an advance every second cycle (STEP, IDLE, STEP, ...).
- The block does not fetch, decode or compute; it only gates `stall`.

## Timing
- Reset (`rstn=0` at an edge) gives:
  - state=IDLE, `stall=1`, `busy=0`, `halted=0`.
  - `v_id=v_ex=0`, `ex_valid=0`, `retired_cnt=0`, `ret=0`.
- Reset overrides every other input, including mid-RUN and mid-STEP.
- `start` sampled at edge N: `stall=0` during cycle N+1.
- Pipeline fill after leaving IDLE from reset:
  - `ex_valid` rises after the 2nd advance edge.
  - The first retire counts at the 3rd advance edge.
- `halt_req` sampled at edge N while in RUN: `stall=1` from cycle N+1.
  - The cycle-N advance still completes.
  - A retire in cycle N still counts.
- Halt-op in cycle N: `stall=1` in cycle N+1, and `ex_valid` reflects the instruction that followed the HALT.
- Resume from HALTED keeps `v_id`/`v_ex` intact, so there is no refill penalty.
- Counter saturation: at all-ones, further retires leave the value unchanged, with no wrap.

## Test plan
- Reset with all inputs at 0 → `stall=1`, `state=0`, `ex_valid=0`, `retired_cnt=0`; these values hold for 10 cycles.
- `start` pulsed 1 cycle, `opcode_ex=4'h1`, run 6 advance cycles → `ex_valid` rises after advance 2 and `retired_cnt=4`.
- In RUN, `halt_req` pulse → `stall=1` the next cycle and `halted=1`. `retired_cnt` is frozen for 5 cycles. A `start` pulse then resumes with `stall=0` next cycle, and the following advance retires immediately.
- In RUN, drive `opcode_ex=4'hF` while `ex_valid=1` → the count includes the HALT and `state=3` next cycle. `halt_req`+`start` asserted together in HALTED → state remains 3.
- From HALTED with a valid pipeline, 3 one-cycle `step` pulses spaced 3 cycles apart → exactly 3 single-cycle `stall=0` windows, `retired_cnt` +3, return to `state=3` after each.
- `CNT_W=3`: 10 retires → `retired_cnt=7`. Then `rstn=0` for 1 cycle mid-RUN → all reset values next cycle, including `ex_valid=0`.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Run-control sequencer for the IF->ID->EX pipeline: drives the shared stall
// line, tracks slot validity, handles halt/step debug and counts retirements.
module pipe_ctrl #(
  parameter logic [3:0] HALT_OPCODE = 4'hF,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic [3:0]       opcode_ex,
  output logic             stall,
  output logic             ex_valid,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic             ret_reg, ret_next;
  logic             v_id_reg, v_ex_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic advance;
  logic retire;
  logic halt_op;

  assign advance = (state_reg == ST_RUN) || (state_reg == ST_STEP);
  assign retire  = advance && v_ex_reg;
  assign halt_op = retire && (opcode_ex == HALT_OPCODE);

  // Next-state logic; halt_req outranks halt-op, which outranks start, then step.
  always_comb begin
    state_next = state_reg;
    ret_next   = ret_reg;
    case (state_reg)
      ST_IDLE: begin
        if (halt_req) begin
          state_next = ST_HALTED;
        end else if (start) begin
          state_next = ST_RUN;
        end else if (step) begin
          state_next = ST_STEP;
          ret_next   = 1'b0;
        end
      end
      ST_RUN: begin
        if (halt_req || halt_op) begin
          state_next = ST_HALTED;
        end
      end
      ST_STEP: begin
        if (halt_req || halt_op || ret_reg) begin
          state_next = ST_HALTED;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (halt_req) begin
          state_next = ST_HALTED;
        end else if (start) begin
          state_next = ST_RUN;
        end else if (step) begin
          state_next = ST_STEP;
          ret_next   = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      ret_reg   <= 1'b0;
      v_id_reg  <= 1'b0;
      v_ex_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ret_reg   <= ret_next;
      // Valid bits freeze with the pipeline so a resume needs no refill.
      if (advance) begin
        v_id_reg <= 1'b1;
        v_ex_reg <= v_id_reg;
      end
      if (retire && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  assign stall       = !advance;
  assign busy        = advance;
  assign halted      = (state_reg == ST_HALTED);
  assign state       = state_reg;
  assign ex_valid    = v_ex_reg;
  assign retired_cnt = cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a wide-counter and a 3-bit-counter instance share stimulus
// and are compared every cycle against an abstract model, plus literal checks.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic        halt_req = 1'b0;
  logic [3:0]  opcode_ex = 4'h0;

  logic        stall_a, ex_valid_a, busy_a, halted_a;
  logic [1:0]  state_a;
  logic [15:0] cnt_a;
  logic        stall_b, ex_valid_b, busy_b, halted_b;
  logic [1:0]  state_b;
  logic [2:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.HALT_OPCODE(4'hF), .CNT_W(16)) dut_a (
    .clk(clk), .rstn(rstn), .start(start), .step(step), .halt_req(halt_req),
    .opcode_ex(opcode_ex), .stall(stall_a), .ex_valid(ex_valid_a), .busy(busy_a),
    .halted(halted_a), .state(state_a), .retired_cnt(cnt_a)
  );

  pipe_ctrl #(.HALT_OPCODE(4'hF), .CNT_W(3)) dut_b (
    .clk(clk), .rstn(rstn), .start(start), .step(step), .halt_req(halt_req),
    .opcode_ex(opcode_ex), .stall(stall_b), .ex_valid(ex_valid_b), .busy(busy_b),
    .halted(halted_b), .state(state_b), .retired_cnt(cnt_b)
  );

  // Abstract model: mode number, count of filled slots (0..2), total retirements.
  int    m_mode  = 0;
  int    m_fill  = 0;
  bit    m_ret   = 0;
  longint m_total = 0;

  always @(posedge clk) begin
    bit adv, ret_now, hop;
    if (!rstn) begin
      m_mode = 0; m_fill = 0; m_ret = 0; m_total = 0;
    end else begin
      adv     = (m_mode == 1) || (m_mode == 2);
      ret_now = adv && (m_fill >= 2);
      hop     = ret_now && (opcode_ex == 4'hF);
      if (ret_now) m_total = m_total + 1;
      if (adv && m_fill < 2) m_fill = m_fill + 1;
      case (m_mode)
        0: if (halt_req) m_mode = 3;
           else if (start) m_mode = 1;
           else if (step) begin m_mode = 2; m_ret = 0; end
        1: if (halt_req || hop) m_mode = 3;
        2: m_mode = (halt_req || hop || m_ret) ? 3 : 0;
        default: if (halt_req) m_mode = 3;
           else if (start) m_mode = 1;
           else if (step) begin m_mode = 2; m_ret = 1; end
      endcase
    end
  end

  function automatic longint sat(longint v, int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit m_busy;
    m_busy = (m_mode == 1) || (m_mode == 2);
    chk("a.stall",    stall_a,    !m_busy);
    chk("a.busy",     busy_a,     m_busy);
    chk("a.halted",   halted_a,   m_mode == 3);
    chk("a.state",    state_a,    m_mode);
    chk("a.ex_valid", ex_valid_a, m_fill >= 2);
    chk("a.cnt",      cnt_a,      sat(m_total, 16));
    chk("b.state",    state_b,    m_mode);
    chk("b.ex_valid", ex_valid_b, m_fill >= 2);
    chk("b.cnt",      cnt_b,      sat(m_total, 3));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then idle for 10 cycles.
    tick(); tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("lit.idle_stall", stall_a, 1);
      chk("lit.idle_state", state_a, 0);
      chk("lit.idle_exv",   ex_valid_a, 0);
      chk("lit.idle_cnt",   cnt_a, 0);
    end

    // Start pulse, 6 advances: ex_valid after the 2nd, 4 retirements.
    opcode_ex = 4'h1; start = 1'b1; tick(); start = 1'b0;
    chk("lit.run_stall", stall_a, 0);
    tick(); chk("lit.exv_after1", ex_valid_a, 0);
    tick(); chk("lit.exv_after2", ex_valid_a, 1);
    tick(); tick(); tick(); tick();
    chk("lit.cnt_after6", cnt_a, 4);

    // halt_req: the same-cycle retire still counts, then frozen.
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("lit.halt_stall", stall_a, 1);
    chk("lit.halted", halted_a, 1);
    chk("lit.halt_cnt", cnt_a, 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lit.frozen_cnt", cnt_a, 5);
    end
    start = 1'b1; tick(); start = 1'b0;
    chk("lit.resume_stall", stall_a, 0);
    tick(); chk("lit.resume_retire", cnt_a, 6);

    // HALT opcode retires and stops; halt_req+start in HALTED stays put.
    opcode_ex = 4'hF; tick(); opcode_ex = 4'h1;
    chk("lit.hop_cnt", cnt_a, 7);
    chk("lit.hop_state", state_a, 3);
    chk("lit.hop_exv", ex_valid_a, 1);
    halt_req = 1'b1; start = 1'b1; tick(); halt_req = 1'b0; start = 1'b0;
    chk("lit.halt_start_state", state_a, 3);

    // Three single steps from HALTED.
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; tick(); step = 1'b0;
      chk("lit.step_stall", stall_a, 0);
      chk("lit.step_state", state_a, 2);
      tick();
      chk("lit.step_back", state_a, 3);
      chk("lit.step_cnt", cnt_a, 8 + i);
      tick();
      chk("lit.step_gap_stall", stall_a, 1);
    end
    chk("lit.sat3", cnt_b, 7);

    // Reset mid-RUN.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rstn = 1'b0; tick(); rstn = 1'b1;
    chk("lit.rst_state", state_a, 0);
    chk("lit.rst_exv", ex_valid_a, 0);
    chk("lit.rst_cnt", cnt_a, 0);
    chk("lit.rst_cnt_b", cnt_b, 0);
    chk("lit.rst_stall", stall_a, 1);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      rstn      = ($urandom_range(0, 299) != 0);
      start     = ($urandom_range(0, 9) == 0);
      step      = ($urandom_range(0, 6) == 0);
      halt_req  = ($urandom_range(0, 24) == 0);
      opcode_ex = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      tick();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
